// File: rtl/core_pkg.sv
// Shared core definitions: data-bus access sizes, interface FSM states and
// the alignment rule used when a load/store request is accepted.
package core_pkg;

   localparam logic [1:0] DBUS_SIZE_B = 2'd0;
   localparam logic [1:0] DBUS_SIZE_H = 2'd1;
   localparam logic [1:0] DBUS_SIZE_W = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } dbusif_state_t;

   // Size 3 is illegal; halves need an even address, words a 4-byte one.
   function automatic logic dbus_misaligned(input logic [1:0] size, input logic [1:0] off);
      dbus_misaligned = (size == 2'd3) ||
                        (size == DBUS_SIZE_H && off[0]) ||
                        (size == DBUS_SIZE_W && off != 2'd0);
   endfunction

endpackage

// File: rtl/dbus_lane.sv
// Byte-lane steering for the data bus: store-side enables and replicated
// write data, load-side alignment and sign/zero extension.
module dbus_lane
   import core_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] wd,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_off,
   input  logic        ld_uns,
   input  logic [31:0] rdata,
   output logic [31:0] rd
);

   logic [31:0] sh;

   always_comb begin
      be    = 4'b0000;
      wdata = wd;
      case (st_size)
         DBUS_SIZE_B: begin
            be    = 4'b0001 << st_off;
            wdata = {4{wd[7:0]}};
         end
         DBUS_SIZE_H: begin
            be    = 4'b0011 << st_off;
            wdata = {2{wd[15:0]}};
         end
         DBUS_SIZE_W: be = 4'hF;
         default:     be = 4'b0000;
      endcase
   end

   always_comb begin
      sh = rdata >> {ld_off, 3'b000};
      case (ld_size)
         DBUS_SIZE_B: rd = {{24{~ld_uns & sh[7]}}, sh[7:0]};
         DBUS_SIZE_H: rd = {{16{~ld_uns & sh[15]}}, sh[15:0]};
         default:     rd = sh;
      endcase
   end

endmodule

// File: rtl/core_dbusif.sv
// Load/store responder for the ID stage: one request at a time, alignment
// check, single-outstanding system bus transfer with timeout abort.
module core_dbusif
   import core_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        dbusif_req,
   input  logic        dbusif_w_rb,
   input  logic [1:0]  dbusif_size,
   input  logic        dbusif_uns,
   input  logic [31:0] dbusif_addr,
   input  logic [31:0] dbusif_wd,
   output logic        dbusif_done,
   output logic        dbusif_err,
   output logic [31:0] dbusif_rd,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata,
   input  logic        bus_err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO = CW'(TIMEOUT);

   dbusif_state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_inc;
   logic          r_w_rb, r_uns;
   logic [1:0]    r_size, r_off;
   logic          accept, bad, timeout;
   logic          done_nxt, err_nxt;
   logic [31:0]   rd_nxt, lane_rd, lane_wdata;
   logic [3:0]    lane_be;

   dbus_lane u_lane (
      .st_size (dbusif_size),
      .st_off  (dbusif_addr[1:0]),
      .wd      (dbusif_wd),
      .be      (lane_be),
      .wdata   (lane_wdata),
      .ld_size (r_size),
      .ld_off  (r_off),
      .ld_uns  (r_uns),
      .rdata   (bus_rdata),
      .rd      (lane_rd)
   );

   assign accept  = dbusif_req && (state != ACCESS);
   assign bad     = accept && dbus_misaligned(dbusif_size, dbusif_addr[1:0]);
   assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
   // cnt holds completed wait cycles, so the abort lands after TIMEOUT cycles of bus_req.
   assign timeout = !bus_ready && (cnt_inc == TO);

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      rd_nxt    = 32'h0;
      case (state)
         ACCESS: begin
            if (bus_ready) begin
               state_nxt = RESP;
               err_nxt   = bus_err;
               rd_nxt    = (bus_err || r_w_rb) ? 32'h0 : lane_rd;
            end else if (timeout) begin
               state_nxt = RESP;
               err_nxt   = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            if (accept) begin
               state_nxt = bad ? RESP : ACCESS;
               err_nxt   = bad;
            end
         end
      endcase
      done_nxt = (state_nxt == RESP);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         dbusif_done <= 1'b0;
         dbusif_err  <= 1'b0;
         dbusif_rd   <= 32'h0;
         bus_req     <= 1'b0;
         bus_we      <= 1'b0;
         bus_addr    <= 32'h0;
         bus_be      <= 4'h0;
         bus_wdata   <= 32'h0;
         cnt         <= '0;
         r_w_rb      <= 1'b0;
         r_uns       <= 1'b0;
         r_size      <= 2'd0;
         r_off       <= 2'd0;
      end else begin
         dbusif_done <= done_nxt;
         dbusif_err  <= err_nxt;
         dbusif_rd   <= rd_nxt;
         if (accept) begin
            r_w_rb <= dbusif_w_rb;
            r_uns  <= dbusif_uns;
            r_size <= dbusif_size;
            r_off  <= dbusif_addr[1:0];
         end
         if (accept && !bad) begin
            bus_req   <= 1'b1;
            bus_we    <= dbusif_w_rb;
            bus_addr  <= {dbusif_addr[31:2], 2'b00};
            bus_be    <= lane_be;
            bus_wdata <= lane_wdata;
            cnt       <= '0;
         end else if (state == ACCESS) begin
            if (bus_ready || timeout) bus_req <= 1'b0;
            else                      cnt     <= cnt_inc;
         end
      end
   end

endmodule

// File: tb/tb_core_dbusif.sv
// Directed bench for core_dbusif: responses are predicted into a queue when a
// request is issued and checked against the done pulse by a monitor.
module tb_core_dbusif;

   logic        clk = 1'b0;
   logic        rstn;
   logic        dbusif_req, dbusif_w_rb, dbusif_uns;
   logic [1:0]  dbusif_size;
   logic [31:0] dbusif_addr, dbusif_wd;
   logic        dbusif_done, dbusif_err;
   logic [31:0] dbusif_rd;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ready, bus_err;
   logic [31:0] bus_rdata;

   typedef struct {
      int          cyc;
      logic        err;
      logic [31:0] rd;
   } resp_t;

   resp_t q[$];
   int    cyc = 0;
   int    nchk = 0;
   int    npass = 0;

   core_dbusif #(.TIMEOUT(4)) dut (
      .clk(clk), .rstn(rstn),
      .dbusif_req(dbusif_req), .dbusif_w_rb(dbusif_w_rb), .dbusif_size(dbusif_size),
      .dbusif_uns(dbusif_uns), .dbusif_addr(dbusif_addr), .dbusif_wd(dbusif_wd),
      .dbusif_done(dbusif_done), .dbusif_err(dbusif_err), .dbusif_rd(dbusif_rd),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Scoreboard monitor: every done pulse must match the oldest prediction.
   always @(negedge clk) begin
      if (rstn === 1'b1 && dbusif_done === 1'b1) begin
         if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
         else begin
            resp_t e;
            e = q.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("done_err", {31'd0, dbusif_err}, {31'd0, e.err});
            chk("done_rd", dbusif_rd, e.rd);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
      dbusif_req = 1'b1; dbusif_w_rb = w; dbusif_size = sz;
      dbusif_uns = u; dbusif_addr = a; dbusif_wd = d;
   endtask

   // Legal access with 'waits' cycles of bus_ready low before the ready cycle.
   task automatic access(input string tag, input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a, input logic [31:0] d,
                         input int waits, input logic [31:0] rdat, input logic berr,
                         input logic [3:0] xbe, input logic [31:0] xwd,
                         input logic xerr, input logic [31:0] xrd);
      q.push_back('{cyc + 2 + waits, xerr, xrd});
      issue(w, sz, u, a, d);
      tick();
      dbusif_req = 1'b0;
      chk({tag, "_be"}, {28'd0, bus_be}, {28'd0, xbe});
      chk({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
      chk({tag, "_we"}, {31'd0, bus_we}, {31'd0, w});
      if (w) chk({tag, "_wdata"}, bus_wdata, xwd);
      for (int i = 0; i <= waits; i++) begin
         chk({tag, "_bus_req"}, {31'd0, bus_req}, 32'd1);
         if (i == waits) begin
            bus_ready = 1'b1; bus_rdata = rdat; bus_err = berr;
         end
         tick();
         bus_ready = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
      end
      chk({tag, "_req_drop"}, {31'd0, bus_req}, 32'd0);
      tick();
   endtask

   task automatic bad_access(input string tag, input logic [1:0] sz, input logic [31:0] a);
      q.push_back('{cyc + 1, 1'b1, 32'h0});
      issue(1'b0, sz, 1'b0, a, 32'h0);
      tick();
      dbusif_req = 1'b0;
      chk({tag, "_no_bus"}, {31'd0, bus_req}, 32'd0);
      tick();
      chk({tag, "_no_bus2"}, {31'd0, bus_req}, 32'd0);
   endtask

   initial begin
      rstn = 1'b0; dbusif_req = 1'b0; dbusif_w_rb = 1'b0; dbusif_size = 2'd0;
      dbusif_uns = 1'b0; dbusif_addr = 32'h0; dbusif_wd = 32'h0;
      bus_ready = 1'b0; bus_rdata = 32'h0; bus_err = 1'b0;
      tick(); tick();
      chk("rst_done", {31'd0, dbusif_done}, 32'd0);
      chk("rst_err", {31'd0, dbusif_err}, 32'd0);
      chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst_be", {28'd0, bus_be}, 32'd0);
      chk("rst_addr", bus_addr, 32'h0);
      chk("rst_wdata", bus_wdata, 32'h0);
      chk("rst_rd", dbusif_rd, 32'h0);
      rstn = 1'b1;
      tick();

      access("lw", 1'b0, 2'd2, 1'b0, 32'h2000_0004, 32'h0, 0, 32'hDEAD_BEEF, 1'b0,
             4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF);
      access("lb", 1'b0, 2'd0, 1'b0, 32'h2000_0003, 32'h0, 0, 32'h8011_2233, 1'b0,
             4'b1000, 32'h0, 1'b0, 32'hFFFF_FF80);
      access("lbu", 1'b0, 2'd0, 1'b1, 32'h2000_0003, 32'h0, 1, 32'h8011_2233, 1'b0,
             4'b1000, 32'h0, 1'b0, 32'h0000_0080);
      access("lh", 1'b0, 2'd1, 1'b0, 32'h2000_0012, 32'h0, 0, 32'h8001_7F00, 1'b0,
             4'b1100, 32'h0, 1'b0, 32'hFFFF_8001);
      access("lhu", 1'b0, 2'd1, 1'b1, 32'h2000_0010, 32'h0, 0, 32'h1234_9ABC, 1'b0,
             4'b0011, 32'h0, 1'b0, 32'h0000_9ABC);
      // Three wait states: ready arrives in the cycle the counter would hit TIMEOUT.
      access("sh", 1'b1, 2'd1, 1'b0, 32'h2000_0002, 32'h0000_ABCD, 3, 32'h5555_5555, 1'b1,
             4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0);
      access("sh_ok", 1'b1, 2'd1, 1'b0, 32'h2000_0002, 32'h0000_ABCD, 3, 32'h5555_5555, 1'b0,
             4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0);
      access("sb", 1'b1, 2'd0, 1'b0, 32'h2000_0001, 32'h0000_00A5, 0, 32'h0, 1'b0,
             4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h0);
      access("berr", 1'b0, 2'd2, 1'b0, 32'h2000_0008, 32'h0, 0, 32'h1111_1111, 1'b1,
             4'hF, 32'h0, 1'b1, 32'h0);

      bad_access("mis_w", 2'd2, 32'h2000_0001);
      bad_access("illegal", 2'd3, 32'h2000_0000);
      bad_access("mis_h", 2'd1, 32'h2000_0003);

      // Timeout: bus_req for 4 cycles, then done+err with bus_req low.
      q.push_back('{cyc + 5, 1'b1, 32'h0});
      issue(1'b0, 2'd2, 1'b0, 32'h3000_0000, 32'h0);
      tick();
      dbusif_req = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         chk("to_bus_req", {31'd0, bus_req}, 32'd1);
         tick();
      end
      chk("to_req_drop", {31'd0, bus_req}, 32'd0);
      tick();

      // Reset in ACCESS kills the request without a done.
      issue(1'b0, 2'd2, 1'b0, 32'h4000_0000, 32'h0);
      tick();
      dbusif_req = 1'b0;
      chk("rst_mid_req", {31'd0, bus_req}, 32'd1);
      rstn = 1'b0;
      tick();
      chk("rst_mid_drop", {31'd0, bus_req}, 32'd0);
      rstn = 1'b1;
      tick(); tick();
      chk("rst_mid_done", {31'd0, dbusif_done}, 32'd0);

      // Back-to-back: second request issued in the RESP cycle of the first.
      q.push_back('{cyc + 2, 1'b0, 32'h0000_0001});
      issue(1'b0, 2'd2, 1'b0, 32'h5000_0000, 32'h0);
      tick();
      dbusif_req = 1'b0;
      bus_ready = 1'b1; bus_rdata = 32'h0000_0001;
      tick();
      bus_ready = 1'b0; bus_rdata = 32'h0;
      q.push_back('{cyc + 2, 1'b0, 32'h0000_0002});
      issue(1'b0, 2'd2, 1'b0, 32'h5000_0010, 32'h0);
      tick();
      dbusif_req = 1'b0;
      chk("b2b_bus_req", {31'd0, bus_req}, 32'd1);
      chk("b2b_addr", bus_addr, 32'h5000_0010);
      bus_ready = 1'b1; bus_rdata = 32'h0000_0002;
      tick();
      bus_ready = 1'b0; bus_rdata = 32'h0;
      tick(); tick();

      chk("sb_empty", q.size(), 32'd0);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/core_dbusif.md
# core_dbusif

Data-bus interface unit of the MCU core: the responder for the ID stage's `dbusif_*` load/store request port. It captures one request at a time, checks alignment, drives a single-outstanding valid/ready system data bus with byte lanes, and returns a one-cycle `dbusif_done` (with `dbusif_err` when applicable) plus aligned, sign- or zero-extended load data for writeback. A timeout counter guarantees completion even if the bus never responds.

## Interface
- `TIMEOUT`, 255: bus cycles to wait for `bus_ready` before aborting with error; range 1..65535.
- `clk` in 1: core clock.
- `rstn` in 1: reset; one clock, synchronous, active-low.
- `dbusif_req` in 1: single-cycle request strobe; ID guarantees no overlap.
- `dbusif_w_rb` in 1: 1 = store, 0 = load.
- `dbusif_size` in 2: 0 byte, 1 half, 2 word, 3 illegal.
- `dbusif_uns` in 1: load zero-extends when 1 (lbu/lhu).
- `dbusif_addr` in 32: byte address.
- `dbusif_wd` in 32: store data, LSB-justified.
- `dbusif_done` out 1: one-cycle completion pulse.
- `dbusif_err` out 1: qualifies `dbusif_done`; misalign, illegal size, bus error or timeout.
- `dbusif_rd` out 32: load result, valid with `dbusif_done & ~dbusif_err & ~w_rb`, else 0.
- `bus_req` out 1: transfer valid; held until `bus_ready` or abort.
- `bus_we` out 1: write.
- `bus_addr` out 32: word-aligned address (`addr[1:0]` forced to 0).
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_ready` in 1: transfer complete this cycle.
- `bus_rdata` in 32: read data, sampled with `bus_ready`.
- `bus_err` in 1: slave error, sampled with `bus_ready`.

## Operation
- States: IDLE, ACCESS, RESP. A request is accepted in IDLE or RESP; a `dbusif_req` in ACCESS is ignored.
- On accept, latch `w_rb`, `size`, `uns` and `addr[1:0]`.
- Misaligned or illegal accept (size 3; size 1 with `addr[0]`; size 2 with `addr[1:0]≠0`) goes to RESP with err set. No bus cycle is issued.
- Legal accept goes to ACCESS. It registers `bus_addr`, `bus_we`, `bus_be` and `bus_wdata`, and clears the timeout counter.
- Byte enables and write data:
  - size 0: `bus_be = 4'b0001 << addr[1:0]`, wdata = `{4{wd[7:0]}}`.
  - size 1: `bus_be = 4'b0011 << addr[1:0]`, wdata = `{2{wd[15:0]}}`.
  - size 2: `bus_be = 4'hF`, wdata = `wd`.
- `bus_be` is driven for reads too.
- In ACCESS, `bus_req = 1`. On `bus_ready`, capture `bus_rdata` and `bus_err`, then go to RESP.
- If `bus_ready` is still low when the counter reaches `TIMEOUT`, drop `bus_req` (abort) and go to RESP with err.
- Counter width is `$clog2(TIMEOUT+1)` and it saturates; it never wraps.
- RESP: `dbusif_done = 1` for exactly one cycle, then IDLE, unless a new request is accepted in the same cycle.
- Load data path:
  - Shift `rdata >> (8*addr[1:0])`.
  - Size 0 extends bit 7; size 1 extends bit 15. Zero-extend when `uns`, sign-extend otherwise.
  - Size 2 passes through.
- Store completion drives `dbusif_rd = 0`.
- Reset mid-ACCESS: `bus_req` drops at the reset edge. No `done` is emitted for the killed request.

## Timing
- Reset values: state IDLE; `dbusif_done`, `dbusif_err`, `bus_req`, `bus_we` = 0; `bus_be` = 0; `bus_addr`, `bus_wdata`, `dbusif_rd` = 0.
- All outputs are registered; nothing is combinational from inputs to outputs.
- Legal access, request at cycle 0:
  - `bus_req` rises at cycle 1.
  - If `bus_ready` is seen at cycle k ≥ 1, `dbusif_done` is high at cycle k+1.
  - Zero-wait-state latency: done 2 cycles after request.
- Misaligned request at cycle 0: `done`+`err` at cycle 1.
- Timeout: `bus_req` high for cycles 1..TIMEOUT; `done`+`err` at cycle TIMEOUT+1 with `bus_req` low.
- `bus_ready` in the same cycle the counter hits `TIMEOUT`: ready wins, completing normally with `bus_err` propagated.
- Back-to-back: a request accepted in RESP gives `bus_req` in the following cycle, with no idle gap.

## Structure
- Shared package `core_pkg`:
  - `DBUS_SIZE_B/H/W` constants (0/1/2).
  - `dbusif_state_t` enum (IDLE, ACCESS, RESP).
- One natural sub-module: `dbus_lane`, purely combinational.
  - Store side: size/offset/wd in, be/wdata out.
  - Load side: size/offset/uns/rdata in, extended rd out.
- Sequential logic (state, counter, capture registers) stays in `core_dbusif`.

## Test plan
- Load word, zero wait: `addr=0x2000_0004`, size 2, `bus_rdata=0xDEAD_BEEF`, ready at cycle 1 → `bus_be=F`, `bus_addr=0x2000_0004`, done at cycle 2, `rd=0xDEAD_BEEF`, err=0.
- Byte load lane and extension: `addr=…03`, size 0, `rdata=0x8011_2233`:
  - `uns=0` → `be=1000`, `rd=0xFFFF_FF80`.
  - `uns=1` → `rd=0x0000_0080`.
- Store half, 3 wait states: `addr=…02`, `wd=0x0000_ABCD` → `be=1100`, `wdata=0xABCD_ABCD`, `bus_req` held for cycles 1..4, done at cycle 5, `rd=0`.
- Misalign and illegal:
  - size 2 at `addr=…01` → done+err at cycle 1, `bus_req` never asserted.
  - size 3 → same response.
- Timeout with `TIMEOUT=4`, `bus_ready` stuck low → `bus_req` high for cycles 1..4, done+err at cycle 5.
- Bus error and reset:
  - `bus_err=1` with ready → done+err.
  - `rstn` low in ACCESS → `bus_req` low next edge, no done.
  - Back-to-back request in RESP → second `bus_req` on the next cycle.
